fib_sequencer: RTL



---
 rtl/fib_pkg.sv | 16 +
 rtl/fib_sequencer.sv | 105 ++++++++++
 2 files changed

// File: rtl/fib_pkg.sv
// Shared types and default geometry for the Fibonacci register-file sequencer.
package fib_pkg;

  localparam int unsigned FIB_ADDR_W    = 6;
  localparam int unsigned FIB_DATA_W    = 32;
  localparam int unsigned FIB_START_IDX = 2;

  typedef enum logic [2:0] {
    IDLE,
    RD_A,
    RD_B,
    WR,
    DONE
  } state_t;

endpackage

// File: rtl/fib_sequencer.sv
// Fills register-file entries START_IDX..last_idx with reg[i] = reg[i-2] + reg[i-1],
// using three cycles per entry: read i-2, read i-1, write i.
module fib_sequencer
  import fib_pkg::*;
#(
  parameter int unsigned ADDR_W    = FIB_ADDR_W,
  parameter int unsigned DATA_W    = FIB_DATA_W,
  parameter int unsigned START_IDX = FIB_START_IDX
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] last_idx,
  output logic [ADDR_W-1:0] rAddr,
  input  logic [DATA_W-1:0] rDout,
  output logic [ADDR_W-1:0] wAddr,
  output logic [DATA_W-1:0] wDin,
  output logic              wEna,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic [DATA_W-1:0] result
);

  state_t            state;
  logic [ADDR_W-1:0] idx;
  logic [ADDR_W-1:0] last_reg;
  logic [DATA_W-1:0] a_reg;
  logic              carry_reg;
  logic [DATA_W:0]   sum_c;

  // The second operand is added as it is read, so wDin leaves a register during WR.
  assign sum_c = {1'b0, a_reg} + {1'b0, rDout};

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= ADDR_W'(START_IDX);
      last_reg  <= '0;
      a_reg     <= '0;
      carry_reg <= 1'b0;
      rAddr     <= '0;
      wAddr     <= '0;
      wDin      <= '0;
      wEna      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      overflow  <= 1'b0;
      result    <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            last_reg <= last_idx;
            idx      <= ADDR_W'(START_IDX);
            overflow <= 1'b0;
            if (last_idx < ADDR_W'(START_IDX)) begin
              state <= DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
            end else begin
              state <= RD_A;
              done  <= 1'b0;
              busy  <= 1'b1;
              rAddr <= ADDR_W'(START_IDX - 2);
            end
          end
        end

        RD_A: begin
          a_reg <= rDout;
          rAddr <= idx - ADDR_W'(1);
          state <= RD_B;
        end

        RD_B: begin
          wAddr     <= idx;
          wDin      <= sum_c[DATA_W-1:0];
          carry_reg <= sum_c[DATA_W];
          wEna      <= 1'b1;
          state     <= WR;
        end

        WR: begin
          wEna     <= 1'b0;
          result   <= wDin;
          overflow <= overflow | carry_reg;
          if (idx == last_reg) begin
            state <= DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end else begin
            // Next entry reads idx+1-2, which is the current idx-1.
            idx   <= idx + ADDR_W'(1);
            rAddr <= idx - ADDR_W'(1);
            state <= RD_A;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
